// File: rtl/alu_display_top.sv
// 5-bit add/sub/mul/div ALU with a scanned 4-digit common-anode seven-segment display.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zeros of the hundreds and tens digits.
module alu_display_top #(
  parameter int REFRESH_BITS = 20
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic [4:0] A,
  input  logic [4:0] B,
  input  logic [1:0] mode,
  output logic [3:0] anode_out,
  output logic [6:0] BCD_ssd
);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [REFRESH_BITS-1:0] CNT_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

  logic [REFRESH_BITS-1:0] refreshCnt_q;
  logic [9:0]              resultMag_q, resultMag_d;
  logic                    resultNeg_q, resultNeg_d;
  logic                    resultErr_q, resultErr_d;
  logic [3:0]              anode_q, anode_d;
  logic [6:0]              seg_q, seg_d;
  logic [1:0]              digitSel;
  logic [11:0]             bcd;
  logic [3:0]              onesDigit, tensDigit, hundredsDigit;

  function automatic logic [6:0] segOf(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Subtraction is kept as sign + magnitude so the display never sees two's complement.
  always_comb begin
    resultMag_d = '0;
    resultNeg_d = 1'b0;
    resultErr_d = 1'b0;
    case (mode)
      2'd0: resultMag_d = {5'd0, A} + {5'd0, B};
      2'd1: begin
        if (A < B) begin
          resultMag_d = {5'd0, B - A};
          resultNeg_d = 1'b1;
        end else begin
          resultMag_d = {5'd0, A - B};
        end
      end
      2'd2: resultMag_d = {5'd0, A} * {5'd0, B};
      default: begin
        if (B == 5'd0) begin
          resultErr_d = 1'b1;
        end else begin
          resultMag_d = {5'd0, A / B};
        end
      end
    endcase
  end

  always_comb begin
    bcd = '0;
    for (int i = 9; i >= 0; i--) begin
      if (bcd[3:0] >= 4'd5)  bcd[3:0]  = bcd[3:0] + 4'd3;
      if (bcd[7:4] >= 4'd5)  bcd[7:4]  = bcd[7:4] + 4'd3;
      if (bcd[11:8] >= 4'd5) bcd[11:8] = bcd[11:8] + 4'd3;
      bcd = {bcd[10:0], resultMag_q[i]};
    end
  end

  assign onesDigit     = bcd[3:0];
  assign tensDigit     = bcd[7:4];
  assign hundredsDigit = bcd[11:8];
  assign digitSel      = refreshCnt_q[REFRESH_BITS-1 -: 2];

  always_comb begin
    anode_d = 4'b1111;
    seg_d   = SEG_BLANK;
    case (digitSel)
      2'd0: begin
        anode_d = 4'b1110;
        seg_d   = segOf(onesDigit);
      end
      2'd1: begin
        anode_d = 4'b1101;
`ifdef LEADING_ZERO_BLANK_EN
        seg_d   = (hundredsDigit == 4'd0 && tensDigit == 4'd0) ? SEG_BLANK : segOf(tensDigit);
`else
        seg_d   = segOf(tensDigit);
`endif
      end
      2'd2: begin
        anode_d = 4'b1011;
`ifdef LEADING_ZERO_BLANK_EN
        seg_d   = (hundredsDigit == 4'd0) ? SEG_BLANK : segOf(hundredsDigit);
`else
        seg_d   = segOf(hundredsDigit);
`endif
      end
      default: begin
        anode_d = 4'b0111;
        seg_d   = resultNeg_q ? SEG_DASH : SEG_BLANK;
      end
    endcase
    if (resultErr_q) seg_d = SEG_DASH;
  end

  // Anode and segments share one register stage so a digit never shows its neighbour's pattern.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      refreshCnt_q <= '0;
      resultMag_q  <= '0;
      resultNeg_q  <= 1'b0;
      resultErr_q  <= 1'b0;
      anode_q      <= 4'b1111;
      seg_q        <= SEG_BLANK;
    end else begin
      refreshCnt_q <= refreshCnt_q + CNT_ONE;
      resultMag_q  <= resultMag_d;
      resultNeg_q  <= resultNeg_d;
      resultErr_q  <= resultErr_d;
      anode_q      <= anode_d;
      seg_q        <= seg_d;
    end
  end

  assign anode_out = anode_q;
  assign BCD_ssd   = seg_q;

endmodule

// File: tb/tb_alu_display_top.sv
// Directed bench for alu_display_top using a 4-bit refresh counter (4 clocks per digit).
module tb_alu_display_top;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DA = 7'b1111110;

  logic       clock_100Mhz = 1'b0;
  logic       reset;
  logic [4:0] A, B;
  logic [1:0] mode;
  logic [3:0] anode_out;
  logic [6:0] BCD_ssd;

  int testCount = 0;
  int failCount = 0;

  alu_display_top #(.REFRESH_BITS(4)) dut (
    .clock_100Mhz(clock_100Mhz),
    .reset(reset),
    .A(A),
    .B(B),
    .mode(mode),
    .anode_out(anode_out),
    .BCD_ssd(BCD_ssd)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Inputs change just after a falling edge; two rising edges later the display reflects them.
  task automatic applyStimulus(input logic [4:0] a, input logic [4:0] b, input logic [1:0] m);
    A = a;
    B = b;
    mode = m;
    repeat (2) @(negedge clock_100Mhz);
  endtask

  task automatic checkDisplay(input string tag, input logic [6:0] expSign, input logic [6:0] expHund,
                              input logic [6:0] expTens, input logic [6:0] expOnes);
    logic [6:0] sign, hund, tens, ones;
    sign = 'x; hund = 'x; tens = 'x; ones = 'x;
    for (int i = 0; i < 16; i++) begin
      case (anode_out)
        4'b1110: ones = BCD_ssd;
        4'b1101: tens = BCD_ssd;
        4'b1011: hund = BCD_ssd;
        4'b0111: sign = BCD_ssd;
        default: ;
      endcase
      @(negedge clock_100Mhz);
    end
    checkOutput({tag, ".sign"}, {9'd0, sign}, {9'd0, expSign});
    checkOutput({tag, ".hund"}, {9'd0, hund}, {9'd0, expHund});
    checkOutput({tag, ".tens"}, {9'd0, tens}, {9'd0, expTens});
    checkOutput({tag, ".ones"}, {9'd0, ones}, {9'd0, expOnes});
  endtask

  initial begin
    logic [3:0] expAnode;
    reset = 1'b0;
    A = 5'd10;
    B = 5'd10;
    mode = 2'd0;
    repeat (3) @(negedge clock_100Mhz);
    checkOutput("reset.anode", {12'd0, anode_out}, 16'h000F);
    checkOutput("reset.seg", {9'd0, BCD_ssd}, {9'd0, BL});

    // Scan order and per-digit dwell straight out of reset.
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock_100Mhz);
      case ((k - 1) / 4)
        0:       expAnode = 4'b1110;
        1:       expAnode = 4'b1101;
        2:       expAnode = 4'b1011;
        default: expAnode = 4'b0111;
      endcase
      checkOutput($sformatf("scan.k%0d", k), {12'd0, anode_out}, {12'd0, expAnode});
    end
    checkDisplay("add10_10", BL, S0, S2, S0);

    applyStimulus(5'd10, 5'd10, 2'd1); checkDisplay("sub10_10", BL, S0, S0, S0);
    applyStimulus(5'd10, 5'd10, 2'd2); checkDisplay("mul10_10", BL, S1, S0, S0);
    applyStimulus(5'd10, 5'd10, 2'd3); checkDisplay("div10_10", BL, S0, S0, S1);
    applyStimulus(5'd15, 5'd5, 2'd0);  checkDisplay("add15_5", BL, S0, S2, S0);
    applyStimulus(5'd15, 5'd5, 2'd1);  checkDisplay("sub15_5", BL, S0, S1, S0);
    applyStimulus(5'd15, 5'd5, 2'd2);  checkDisplay("mul15_5", BL, S0, S7, S5);
    applyStimulus(5'd15, 5'd5, 2'd3);  checkDisplay("div15_5", BL, S0, S0, S3);
    applyStimulus(5'd5, 5'd15, 2'd1);  checkDisplay("sub5_15", DA, S0, S1, S0);
    applyStimulus(5'd31, 5'd31, 2'd2); checkDisplay("mul31_31", BL, S9, S6, S1);
    applyStimulus(5'd31, 5'd0, 2'd3);  checkDisplay("div31_0", DA, DA, DA, DA);
    applyStimulus(5'd31, 5'd1, 2'd3);  checkDisplay("div31_1", BL, S0, S3, S1);

    // Reset between edges must blank the display without waiting for a clock.
    @(negedge clock_100Mhz);
    #2 reset = 1'b0;
    #1;
    checkOutput("midreset.anode", {12'd0, anode_out}, 16'h000F);
    checkOutput("midreset.seg", {9'd0, BCD_ssd}, {9'd0, BL});
    repeat (2) @(negedge clock_100Mhz);
    checkOutput("heldreset.anode", {12'd0, anode_out}, 16'h000F);
    reset = 1'b1;
    @(negedge clock_100Mhz);
    checkOutput("restart.anode", {12'd0, anode_out}, 16'h000E);
    @(negedge clock_100Mhz);
    checkOutput("restart.ones", {9'd0, BCD_ssd}, {9'd0, S1});

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_display_top.md
Name: alu_display_top

Overview:
- 5-bit two-operand ALU (add, subtract, multiply, divide) with a time-multiplexed 4-digit common-anode seven-segment display driver.
- The result is shown in decimal: sign digit, then hundreds, tens and ones.
- FPGA board top level, clocked from a 100 MHz oscillator; A, B and mode come from switches.

Parameters:
- REFRESH_BITS, 20, width of the display refresh counter. The top 2 bits select the active digit, so each digit is on for 2^18 clocks (about 2.6 ms at 100 MHz).

Ports:
- clock_100Mhz  input  1  system clock, 100 MHz, rising edge
- reset  input  1  asynchronous, active-low reset
- A  input  5  operand A, unsigned 0..31
- B  input  5  operand B, unsigned 0..31
- mode  input  2  operation: 0 add, 1 subtract, 2 multiply, 3 divide
- anode_out  output  4  digit enables, active-low; bit3 = leftmost digit
- BCD_ssd  output  7  segments {a,b,c,d,e,f,g} on bits [6:0], active-low

Behaviour:
- One clock (clock_100Mhz); asynchronous active-low reset. All flops clear immediately when reset=0.
- Values while reset=0:
  - result register = 0, error flag = 0, refresh counter = 0
  - anode_out = 4'b1111 (all digits off)
  - BCD_ssd = 7'b1111111 (all segments off)
- ALU, combinational, registered into the result register on each rising edge (1-cycle latency):
  - mode 0: A+B, range 0..62.
  - mode 1: A−B, signed. Magnitude is |A−B| and neg=1 when A<B.
  - mode 2: A*B, range 0..961.
  - mode 3: A/B, integer quotient, truncated. B=0 sets the error flag and forces the magnitude to 0.
- Stored result: 10-bit magnitude, neg bit, err bit.
- BCD conversion: combinational binary-to-BCD of the stored magnitude (double-dabble or equivalent) into hundreds, tens and ones, each 0..9.
- Refresh counter: REFRESH_BITS wide, free-running, increments every clock, wraps to 0. sel = counter[MSB:MSB-1].
- Digit scan by sel:
  - sel 0: anode_out=1110, ones digit
  - sel 1: anode_out=1101, tens digit
  - sel 2: anode_out=1011, hundreds digit
  - sel 3: anode_out=0111, sign digit
- Sign digit shows '-' (only segment g lit, BCD_ssd=7'b1111110) when neg=1; otherwise it is blank (7'b1111111).
- Error display: when err=1, all four digits show '-'.
- Leading zeros of hundreds and tens are displayed as '0'.
- anode_out and BCD_ssd are registered: one clock after the sel/result change, and they change together (no ghosting mismatch).
- Segment codes, active-low abcdefg:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- Input changes are reflected on the displayed digits within 2 clocks.
- Reset asserted mid-scan returns all outputs to the off state immediately. After reset is released, scanning restarts at sel 0.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Hundreds digit is blanked when hundreds=0.
  - Tens digit is blanked when hundreds=0 and tens=0.
  - Ones digit is always shown.
  - The '-' sign stays in the sign position.
- Undefined: leading zeros are shown as '0' as described in Behaviour.

Test Plan:
- reset=0, then release; A=10, B=10, mode 0. Capture each anode phase -> digits read blank,0,2,0: ones 0000001, tens 0010010, hundreds 0000001, sign 1111111. Each anode is low for 2^18 clocks, in order 1110,1101,1011,0111.
- A=10, B=10, modes 1, 2, 3 -> displays 000, 100, 001.
- A=15, B=5, modes 0..3 -> displays 020, 010, 075, 003; sign blank throughout.
- A=5, B=15, mode 1 -> sign digit 1111110 ('-'), magnitude 010. Then A=31, B=31, mode 2 -> 961.
- B=0, mode 3 -> all four digits 1111110. Then set B=1 -> quotient equal to A shown within 2 clocks.
- Pull reset low mid-scan -> anode_out=1111 and BCD_ssd=1111111 immediately. Release -> scan restarts at anode 1110.
